score_tracker: RTL

Game-score bookkeeping stage for the jump game. It accumulates points from landing events, tracks a perfect-landing combo and a session best score, and runs the IDLE/PLAYING/OVER game-phase FSM. It drives the 10-bit decimal score into the downstream four-digit seven-segment score display stage. All outputs are registered except `o_disp_score`, which is a registered-input mux.

---
 rtl/score_tracker_if.sv | 25 ++
 rtl/score_tracker.sv | 97 +++++++++
 2 files changed

// File: rtl/score_tracker_if.sv
// Handshake bundle between the game controller and the score bookkeeping stage.
// Carries the event pulses in and the score/phase/display values out.
interface score_tracker_if;
    logic       i_start;
    logic       i_land_valid;
    logic       i_land_perfect;
    logic       i_game_over;
    logic       i_show_best;
    logic [9:0] o_score;
    logic [9:0] o_best;
    logic [3:0] o_combo;
    logic [1:0] o_state;
    logic       o_new_best;
    logic [9:0] o_disp_score;

    modport master (
        output i_start, i_land_valid, i_land_perfect, i_game_over, i_show_best,
        input  o_score, o_best, o_combo, o_state, o_new_best, o_disp_score
    );

    modport slave (
        input  i_start, i_land_valid, i_land_perfect, i_game_over, i_show_best,
        output o_score, o_best, o_combo, o_state, o_new_best, o_disp_score
    );
endinterface

// File: rtl/score_tracker.sv
// Jump-game score bookkeeping: landing points, perfect-landing combo, session best
// and the IDLE/PLAYING/OVER phase FSM feeding the score display.
module score_tracker #(
    parameter int unsigned MAX_SCORE = 999,
    parameter int unsigned MAX_COMBO = 8
) (
    input logic            clk,
    input logic            rst,
    score_tracker_if.slave bus
);

    localparam logic [10:0] SCORE_CAP = 11'(MAX_SCORE);
    localparam logic [3:0]  COMBO_CAP = 4'(MAX_COMBO);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StPlaying = 2'b01,
        StOver    = 2'b10
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] score_q, score_d;
    logic [9:0] best_q, best_d;
    logic [3:0] combo_q, combo_d;
    logic       new_best_q, new_best_d;

    logic [3:0]  combo_inc;
    logic [10:0] score_add;
    logic [10:0] score_sum;
    logic [9:0]  score_land;

    // Landing arithmetic is done one bit wider so the clamp sees any overflow.
    always_comb begin
        combo_inc  = (combo_q >= COMBO_CAP) ? COMBO_CAP : combo_q + 4'd1;
        score_add  = bus.i_land_perfect ? {6'd0, combo_inc, 1'b0} : 11'd1;
        score_sum  = {1'b0, score_q} + score_add;
        score_land = (score_sum > SCORE_CAP) ? SCORE_CAP[9:0] : score_sum[9:0];
    end

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        combo_d    = combo_q;
        best_d     = best_q;
        new_best_d = new_best_q;
        case (state_q)
            StIdle, StOver: begin
                if (bus.i_start) begin
                    state_d    = StPlaying;
                    score_d    = '0;
                    combo_d    = '0;
                    new_best_d = 1'b0;
                end
            end
            StPlaying: begin
                if (bus.i_land_valid) begin
                    score_d = score_land;
                    combo_d = bus.i_land_perfect ? combo_inc : 4'd0;
                end
                // A landing on the same edge counts toward the final score.
                if (bus.i_game_over) begin
                    state_d = StOver;
                    if (score_d > best_q) begin
                        best_d     = score_d;
                        new_best_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            score_q    <= '0;
            best_q     <= '0;
            combo_q    <= '0;
            new_best_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            best_q     <= best_d;
            combo_q    <= combo_d;
            new_best_q <= new_best_d;
        end
    end

    assign bus.o_score    = score_q;
    assign bus.o_best     = best_q;
    assign bus.o_combo    = combo_q;
    assign bus.o_state    = state_q;
    assign bus.o_new_best = new_best_q;

    assign bus.o_disp_score = (state_q == StPlaying || !bus.i_show_best) ? score_q : best_q;

endmodule
